// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack memory handshake,
// holds one instruction for decode and steps the PC from decode's branch/jump controls.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic [31:0]      instr_pc,
  output logic             instr_valid,
  input  logic             instr_ready,
  input  logic             branch,
  input  logic             branch_cond,
  input  logic             jump,
  input  logic [15:0]      imm16,
  input  logic [25:0]      target,
  output logic             fetch_err,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam int unsigned TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_ERR} state_t;

  state_t           state, state_nxt;
  logic [31:0]      pc, pc_nxt;
  logic [31:0]      instr_q, instr_nxt;
  logic [TO_W-1:0]  to_cnt, to_cnt_nxt;
  logic [CNT_W-1:0] ret_q, ret_nxt;
  logic [31:0]      seq_pc, br_off, next_pc;
  logic             to_last;

  assign seq_pc  = pc + 32'd4;
  assign br_off  = {{14{imm16[15]}}, imm16, 2'b00};
  // With TIMEOUT=0 the counter just wraps and never reaches the error condition.
  assign to_last = (TIMEOUT != 0) && (to_cnt == TO_W'(TIMEOUT - 1));

  always_comb begin
    next_pc = seq_pc;
    if (jump)
      next_pc = {seq_pc[31:28], target, 2'b00};
    else if (branch && branch_cond)
      next_pc = seq_pc + br_off;
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    instr_nxt   = instr_q;
    to_cnt_nxt  = to_cnt;
    ret_nxt     = ret_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    fetch_err   = 1'b0;
    unique case (state)
      S_IDLE: begin
        state_nxt  = S_REQ;
        to_cnt_nxt = '0;
      end
      S_REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          state_nxt = S_HOLD;
          instr_nxt = imem_rdata;
        end else if (to_last) begin
          state_nxt = S_ERR;
        end else begin
          to_cnt_nxt = to_cnt + TO_W'(1);
        end
      end
      S_HOLD: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          state_nxt  = S_REQ;
          pc_nxt     = next_pc;
          ret_nxt    = ret_q + CNT_W'(1);
          to_cnt_nxt = '0;
        end
      end
      S_ERR: begin
        fetch_err = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      instr_q <= '0;
      to_cnt  <= '0;
      ret_q   <= '0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      instr_q <= instr_nxt;
      to_cnt  <= to_cnt_nxt;
      ret_q   <= ret_nxt;
    end
  end

  assign imem_addr   = pc;
  assign instr_pc    = pc;
  assign instr       = instr_q;
  assign retired_cnt = ret_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: expected fetch addresses and held instructions
// are queued when stimulus is driven and compared when the DUT presents them.
module tb_ifetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam int unsigned TIMEOUT  = 16;
  localparam int unsigned CNT_W    = 32;

  logic             clk;
  logic             rst;
  logic             imem_req;
  logic [31:0]      imem_addr;
  logic             imem_ack;
  logic [31:0]      imem_rdata;
  logic [31:0]      instr;
  logic [31:0]      instr_pc;
  logic             instr_valid;
  logic             instr_ready;
  logic             branch;
  logic             branch_cond;
  logic             jump;
  logic [15:0]      imm16;
  logic [25:0]      target;
  logic             fetch_err;
  logic [CNT_W-1:0] retired_cnt;

  ifetch_unit #(
    .RESET_PC(RESET_PC),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .branch     (branch),
    .branch_cond(branch_cond),
    .jump       (jump),
    .imm16      (imm16),
    .target     (target),
    .fetch_err  (fetch_err),
    .retired_cnt(retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_instr_q[$];
  logic [31:0] model_pc;
  logic [31:0] model_ret;
  logic [63:0] held;
  int          w;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] calc_next(input logic [31:0] pc, input logic br,
                                            input logic cond, input logic j,
                                            input logic [15:0] imm, input logic [25:0] tgt);
    logic [31:0] s;
    logic [31:0] off;
    s   = pc + 32'd4;
    off = {{16{imm[15]}}, imm};
    if (j)             return (s & 32'hF000_0000) | ({6'd0, tgt} << 2);
    else if (br && cond) return s + (off << 2);
    else               return s;
  endfunction

  task automatic scramble_ctrl();
    branch      = 1'($urandom);
    branch_cond = 1'($urandom);
    jump        = 1'($urandom);
    imm16       = 16'($urandom);
    target      = 26'($urandom);
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    imem_ack    = 1'b0;
    instr_ready = 1'b0;
    exp_addr_q.delete();
    exp_instr_q.delete();
    repeat (2) @(negedge clk);
    check("rst_req",   64'(imem_req),    64'(0));
    check("rst_valid", 64'(instr_valid), 64'(0));
    check("rst_err",   64'(fetch_err),   64'(0));
    check("rst_addr",  64'(imem_addr),   64'(RESET_PC));
    check("rst_instr", 64'(instr),       64'(0));
    check("rst_ret",   64'(retired_cnt), 64'(0));
    rst       = 1'b1;
    model_pc  = RESET_PC;
    model_ret = '0;
    exp_addr_q.push_back(RESET_PC);
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (imem_req !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) check("req_wait_expired", 64'(0), 64'(1));
  endtask

  task automatic pop_addr();
    if (exp_addr_q.size() == 0) check("addr_queue_empty", 64'(1), 64'(0));
    else check("imem_addr", 64'(imem_addr), 64'(exp_addr_q.pop_front()));
  endtask

  task automatic fetch(input int lat, input logic [31:0] data, output int req_wait);
    wait_req(req_wait);
    pop_addr();
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      check("req_held", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, model_pc});
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    exp_instr_q.push_back({data, model_pc});
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    check("instr_valid", 64'(instr_valid), 64'(1));
    check("fetch_err_clear", 64'(fetch_err), 64'(0));
    held = exp_instr_q.pop_front();
    check("instr_word_pc", {instr, instr_pc}, held);
  endtask

  task automatic consume(input logic br, input logic cond, input logic j,
                         input logic [15:0] imm, input logic [25:0] tgt);
    logic [31:0] nxt;
    instr_ready = 1'b1;
    branch      = br;
    branch_cond = cond;
    jump        = j;
    imm16       = imm;
    target      = tgt;
    nxt = calc_next(model_pc, br, cond, j, imm, tgt);
    exp_addr_q.push_back(nxt);
    model_pc  = nxt;
    model_ret = model_ret + 32'd1;
    @(negedge clk);
    instr_ready = 1'b0;
    scramble_ctrl();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    branch = 1'b0; branch_cond = 1'b0; jump = 1'b0; imm16 = '0; target = '0;
    do_reset();

    // first fetch with 3-cycle memory latency
    fetch(3, 32'h2008_0005, w);

    // zero-wait sequential stream: new request one cycle after consume
    for (int i = 0; i < 3; i++) begin
      consume(1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
      fetch(0, $urandom, w);
      check("req_latency", 64'(w), 64'(0));
    end
    check("retired_3", 64'(retired_cnt), 64'(model_ret));
    consume(1'b0, 1'b1, 1'b0, 16'h1234, 26'h0);
    fetch(0, $urandom, w);

    // backward taken branch at 3010, then not-taken and branch=0 cases
    consume(1'b1, 1'b1, 1'b0, 16'hFFFC, 26'h0);
    fetch(1, $urandom, w);
    for (int i = 0; i < 3; i++) begin
      consume(1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
      fetch(0, $urandom, w);
    end
    consume(1'b1, 1'b0, 1'b0, 16'hFFFC, 26'h0);
    fetch(0, $urandom, w);
    consume(1'b0, 1'b1, 1'b0, 16'h0040, 26'h0);
    fetch(0, $urandom, w);
    for (int i = 0; i < 2; i++) begin
      consume(1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
      fetch(0, $urandom, w);
    end

    // jump beats taken branch at 3020
    consume(1'b1, 1'b1, 1'b1, 16'hFFFC, 26'h0000C10);
    fetch(2, $urandom, w);

    // forward branch, then ack on the last allowed REQ cycle
    consume(1'b1, 1'b1, 1'b0, 16'h0010, 26'h0);
    fetch(int'(TIMEOUT) - 1, 32'hCAFE_F00D, w);

    // hold for 5 cycles with stray controls and acks that must be ignored
    for (int i = 0; i < 5; i++) begin
      scramble_ctrl();
      imem_ack   = 1'($urandom);
      imem_rdata = $urandom;
      @(negedge clk);
      check("hold_instr", {instr, instr_pc}, held);
      check("hold_valid_noreq", {62'd0, instr_valid, imem_req}, {62'd0, 2'b10});
    end
    imem_ack = 1'b0;
    check("retired_mid", 64'(retired_cnt), 64'(model_ret));
    consume(1'b0, 1'b0, 1'b0, 16'h0, 26'h0);

    // asynchronous reset mid-REQ with a pending ack
    wait_req(w);
    pop_addr();
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    rst        = 1'b0;
    #1;
    check("async_rst_req",  {62'd0, imem_req, instr_valid}, 64'(0));
    check("async_rst_addr", 64'(imem_addr), 64'(RESET_PC));
    do_reset();
    fetch(0, 32'h1111_2222, w);
    consume(1'b0, 1'b0, 1'b0, 16'h0, 26'h0);

    // no ack: error after TIMEOUT REQ cycles, then absorbing
    wait_req(w);
    pop_addr();
    repeat (TIMEOUT - 1) @(negedge clk);
    check("to_last_cycle", {62'd0, imem_req, fetch_err}, {62'd0, 2'b10});
    @(negedge clk);
    check("to_err", {61'd0, fetch_err, imem_req, instr_valid}, {61'd0, 3'b100});
    imem_ack = 1'b1;
    repeat (3) @(negedge clk);
    check("err_sticky", {61'd0, fetch_err, imem_req, instr_valid}, {61'd0, 3'b100});
    imem_ack = 1'b0;

    do_reset();
    fetch(0, $urandom, w);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
